// File: rtl/param_updown_counter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : param_updown_counter
// Brief    : Parametrised synchronous up/down counter with load, wrap or
//            saturate, boundary flags and a registered wrap pulse.
//            Optional prescaler is enabled by defining UDC_PRESCALE_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module param_updown_counter #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] MAX_VAL   = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
`ifdef UDC_PRESCALE_EN
    ,
    parameter int               PRESCALE  = 4
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             wrap_pulse
);

    localparam logic [WIDTH-1:0] c_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] c_ZERO = {WIDTH{1'b0}};

    logic [WIDTH-1:0] r_count;
    logic             r_wrap_pulse;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_load_clamped;
    logic             w_wrap_event;
    logic             w_at_max;
    logic             w_at_min;
    logic             w_step;

    assign w_at_max = (r_count == MAX_VAL);
    assign w_at_min = (r_count == c_ZERO);

    // Boundary tests come first so the add/subtract never leaves the range.
    always_comb begin
        w_next       = r_count;
        w_wrap_event = 1'b0;
        if (up) begin
            if (!w_at_max) begin
                w_next = r_count + c_ONE;
            end else if (!sat) begin
                w_next       = c_ZERO;
                w_wrap_event = 1'b1;
            end
        end else begin
            if (!w_at_min) begin
                w_next = r_count - c_ONE;
            end else if (!sat) begin
                w_next       = MAX_VAL;
                w_wrap_event = 1'b1;
            end
        end
    end

    assign w_load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

`ifdef UDC_PRESCALE_EN
    localparam int                 c_PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(PRESCALE - 1);
    localparam logic [c_PRE_W-1:0] c_PRE_ONE  = {{(c_PRE_W-1){1'b0}}, 1'b1};

    logic [c_PRE_W-1:0] r_pre;

    // Prescaler only advances on enabled cycles; load restarts a full interval.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            r_pre <= '0;
        end else if (en) begin
            r_pre <= (r_pre == c_PRE_LAST) ? '0 : r_pre + c_PRE_ONE;
        end
    end

    assign w_step = en && (r_pre == c_PRE_LAST);
`else
    assign w_step = en;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count      <= RESET_VAL;
            r_wrap_pulse <= 1'b0;
        end else if (load) begin
            r_count      <= w_load_clamped;
            r_wrap_pulse <= 1'b0;
        end else if (w_step) begin
            r_count      <= w_next;
            r_wrap_pulse <= w_wrap_event;
        end else begin
            r_wrap_pulse <= 1'b0;
        end
    end

    assign count      = r_count;
    assign at_max     = w_at_max;
    assign at_min     = w_at_min;
    assign wrap_pulse = r_wrap_pulse;

endmodule
`default_nettype wire

// File: tb/tb_param_updown_counter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_param_updown_counter
// Brief    : Self-checking bench driving a full-range 8-bit counter and a
//            modulo-10 counter in lockstep against a scoreboard model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_param_updown_counter;

    localparam int unsigned c_MAX[2] = '{255, 9};
    localparam int unsigned c_RST[2] = '{0, 3};
    localparam int unsigned c_PRESCALE = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic       sat = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'd0;

    logic [7:0] count8;
    logic       at_max8, at_min8, wrap8;
    logic [3:0] count4;
    logic       at_max4, at_min4, wrap4;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int unsigned cnt[2];
        bit          wr[2];
    } exp_t;

    exp_t        sb[$];
    int unsigned m_cnt[2];
    bit          m_wr[2];
    int unsigned m_pre[2];

    always #5 clk = ~clk;

    param_updown_counter #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat), .load(load),
        .load_val(load_val), .count(count8), .at_max(at_max8),
        .at_min(at_min8), .wrap_pulse(wrap8)
    );

    param_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .RESET_VAL(4'd3)) u_dut4 (
        .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat), .load(load),
        .load_val(load_val[3:0]), .count(count4), .at_max(at_max4),
        .at_min(at_min4), .wrap_pulse(wrap4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference behaviour for one rising edge, applied to both counters.
    task automatic model_edge();
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            int unsigned lv;
            bit          stepok;
            lv = (d == 0) ? int'(load_val) : int'(load_val[3:0]);
`ifdef UDC_PRESCALE_EN
            stepok = en && (m_pre[d] == c_PRESCALE - 1);
`else
            stepok = en;
`endif
            m_wr[d] = 1'b0;
            if (rst) begin
                m_cnt[d] = c_RST[d];
                m_pre[d] = 0;
            end else if (load) begin
                m_cnt[d] = (lv > c_MAX[d]) ? c_MAX[d] : lv;
                m_pre[d] = 0;
            end else begin
                if (en) m_pre[d] = (m_pre[d] == c_PRESCALE - 1) ? 0 : m_pre[d] + 1;
                if (stepok) begin
                    if (up) begin
                        if (m_cnt[d] < c_MAX[d]) m_cnt[d]++;
                        else if (!sat) begin m_cnt[d] = 0; m_wr[d] = 1'b1; end
                    end else begin
                        if (m_cnt[d] > 0) m_cnt[d]--;
                        else if (!sat) begin m_cnt[d] = c_MAX[d]; m_wr[d] = 1'b1; end
                    end
                end
            end
            e.cnt[d] = m_cnt[d];
            e.wr[d]  = m_wr[d];
        end
        sb.push_back(e);
    endtask

    task automatic compare_outputs();
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL sb_empty: observed %0d expected %0d", 0, 1);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("count8", 32'(count8), e.cnt[0]);
            chk("wrap8", 32'(wrap8), 32'(e.wr[0]));
            chk("at_max8", 32'(at_max8), 32'(e.cnt[0] == c_MAX[0]));
            chk("at_min8", 32'(at_min8), 32'(e.cnt[0] == 0));
            chk("count4", 32'(count4), e.cnt[1]);
            chk("wrap4", 32'(wrap4), 32'(e.wr[1]));
            chk("at_max4", 32'(at_max4), 32'(e.cnt[1] == c_MAX[1]));
            chk("at_min4", 32'(at_min4), 32'(e.cnt[1] == 0));
        end
    endtask

    // Inputs are applied 1 time unit after an edge, outputs sampled likewise.
    task automatic cycle(input bit r, input bit l, input int unsigned lv,
                         input bit e, input bit u, input bit s);
        rst = r; load = l; load_val = 8'(lv); en = e; up = u; sat = s;
        model_edge();
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    initial begin
        @(posedge clk);
        #1;

        // Reset state
        cycle(1, 0, 0, 0, 0, 0);
        chk("reset_val4", 32'(count4), 32'd3);
        chk("reset_val8", 32'(count8), 32'd0);

        // Full-range up count through the 255 -> 0 wrap
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 257; i++) cycle(0, 0, 0, 1, 1, 0);

        // Down wrap on the modulo-10 counter
        cycle(0, 1, 0, 1, 0, 0);
        for (int i = 0; i < 12; i++) cycle(0, 0, 0, 1, 0, 0);

        // Saturate at both boundaries
        cycle(0, 1, 8, 0, 1, 1);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 1, 1);
        cycle(0, 1, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0, 1);

        // Load priority, clamp, reset dominance
        cycle(0, 1, 5, 1, 1, 0);
        chk("load_prio4", 32'(count4), 32'd5);
        cycle(0, 1, 12, 1, 1, 0);
        chk("load_clamp4", 32'(count4), 32'd9);
        chk("load_noclamp8", 32'(count8), 32'd12);
        cycle(1, 1, 7, 1, 1, 0);
        chk("rst_wins4", 32'(count4), 32'd3);

        // Direction reversal, then hold
        cycle(0, 1, 5, 0, 1, 0);
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1, (i % 2) == 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, 0);

        // Reset while a wrap pulse would be pending
        cycle(0, 1, 9, 0, 1, 0);
        cycle(1, 0, 0, 1, 1, 0);
        chk("rst_clears_wrap4", 32'(wrap4), 32'd0);

        // Mixed random traffic
        for (int i = 0; i < 300; i++) begin
            cycle($urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 255), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
- Parametrised synchronous up/down counter; successor to the fixed 8-bit T-flip-flop up/down counter.
- Adds configurable width and modulus, count enable, parallel load, wrap/saturate mode, boundary flags and a registered wrap pulse.
- Used as a general event/timer counter in datapath and control blocks; counters can be chained through wrap_pulse.

Parameters:
- WIDTH, 8, counter width in bits (2..32).
- MAX_VAL, 2**WIDTH-1, upper count limit; range is 0..MAX_VAL; legal values are 1..2**WIDTH-1.
- RESET_VAL, 0, count value after reset; must be <= MAX_VAL.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  count enable; counter steps only when high.
- up  in  1  direction; 1 = increment, 0 = decrement.
- sat  in  1  boundary mode; 0 = wrap, 1 = saturate.
- load  in  1  parallel load strobe.
- load_val  in  WIDTH  value loaded when load is high.
- count  out  WIDTH  current count (registered).
- at_max  out  1  combinational; high when count == MAX_VAL.
- at_min  out  1  combinational; high when count == 0.
- wrap_pulse  out  1  registered; one-cycle pulse on the cycle after a wrap event.

Behaviour:
- Reset is synchronous: with rst high at a rising edge, count = RESET_VAL and wrap_pulse = 0. at_max and at_min follow count.
- Priority at each rising edge: rst, then load, then en, then hold.
- Load: count = load_val. If load_val > MAX_VAL, count = MAX_VAL (clamp). wrap_pulse = 0. en and up are ignored in that cycle.
- Count step when en = 1 and load = 0:
  - up = 1, count < MAX_VAL: count + 1.
  - up = 0, count > 0: count - 1.
  - up = 1, count == MAX_VAL, sat = 0: count = 0; wrap event.
  - up = 0, count == 0, sat = 0: count = MAX_VAL; wrap event.
  - At either boundary with sat = 1: count holds; no wrap event.
- wrap_pulse: high for exactly the one cycle after the edge at which the wrap occurred, otherwise 0. Back-to-back wraps (e.g. MAX_VAL = 1, en held, wrap mode) give wrap_pulse high on consecutive cycles.
- en = 0: count holds and wrap_pulse = 0. up and sat are don't-care.
- up, sat and en may change on any cycle; each edge uses only the values sampled at that edge. Direction reversal takes effect on the next step with no bubble.
- Latency: count reflects a step, load or reset one cycle after the sampling edge. Flags are combinational from count.
- Arithmetic is unsigned WIDTH-bit. No intermediate result may exceed the WIDTH-bit range; boundary compares come before add/subtract.
- rst asserted mid-count, or together with load and en: reset wins and any pending wrap_pulse is cleared.

Optional Feature:
- Macro: UDC_PRESCALE_EN.
- Defined: adds parameter PRESCALE (default 4, >= 1) and an internal prescale counter 0..PRESCALE-1.
  - The main counter steps only on enabled cycles where the prescaler equals PRESCALE-1.
  - The prescaler advances on every en = 1 cycle and wraps to 0.
  - rst and load both clear the prescaler to 0.
  - en = 0 holds the prescaler.
  - Wrap and saturate rules for the main counter are unchanged.
- Undefined: no prescaler logic exists and the counter steps on every enabled cycle. Port list is identical in both builds.

Test Plan:
- Reset then count up in wrap mode: WIDTH = 8, MAX_VAL = 255, rst 1 cycle, then en = 1, up = 1, sat = 0 for 256 cycles → count goes 0,1,…,255,0; wrap_pulse high exactly one cycle, after the 255→0 edge; at_max high only while count = 255.
- Down wrap with custom modulus: MAX_VAL = 9, load 0, then en = 1, up = 0 → count 9,8,…,0,9; wrap_pulse after the 0→9 edge; at_min high while count = 0.
- Saturate at both boundaries: MAX_VAL = 9, sat = 1, load 8, up = 1 for 4 cycles → 9,9,9, no wrap_pulse; then up = 0 from 1 for 3 cycles → 0,0, no wrap_pulse.
- Load priority and clamp: MAX_VAL = 9, en = 1, up = 1, load = 1 with load_val = 5 → count = 5, not 6; load_val = 12 → count = 9; rst = 1 and load = 1 in the same cycle → count = RESET_VAL.
- Direction reversal and hold: count 5, up toggling every cycle with en = 1 → 6,5,6,5; then en = 0 for 3 cycles → count frozen and wrap_pulse = 0.
- UDC_PRESCALE_EN build: PRESCALE = 4, en = 1, up = 1 from 0 → count increments every 4th cycle (0,0,0,1,…); load mid-prescale restarts a full 4-cycle interval.
